// File: rtl/placement_scheduler.sv
// Purpose: AI move selector; walks every (rotation, column) placement, scores the legal
//          boards through the analyzer and keeps the lowest-scoring candidate.
// Latency: legal candidate 6 cycles, illegal 2 cycles (1-cycle ack, 2-cycle analyzer), +2 per search.
// Backpressure: cand_req is held until cand_ack; each wait (ack or recv_score) is bounded by TIMEOUT.
// Ports: clk/rst_n (async active-low); start/abort/busy/done/error to the game FSM;
//        best_* result; cand_req/cand_rot/cand_col/cand_ack/cand_legal to the placement generator;
//        req_score/recv_score/score to the board analyzer.
module placement_scheduler #(
    parameter int NUM_ROT = 4,
    parameter int NUM_COL = 10,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        best_valid,
    output logic [1:0]  best_rot,
    output logic [3:0]  best_col,
    output logic [31:0] best_score,
    output logic        cand_req,
    output logic [1:0]  cand_rot,
    output logic [3:0]  cand_col,
    input  logic        cand_ack,
    input  logic        cand_legal,
    output logic        req_score,
    input  logic        recv_score,
    input  logic [31:0] score
);

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_SCORE, S_WAIT, S_UPDATE, S_NEXT, S_FINISH
    } state_t;

    localparam int          TW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [1:0]  ROT_LAST  = 2'(NUM_ROT - 1);
    localparam logic [3:0]  COL_LAST  = 4'(NUM_COL - 1);
    localparam logic [31:0] SCORE_MAX = 32'h7FFF_FFFF;

    state_t         state_q;
    logic [1:0]     rot_q;
    logic [3:0]     col_q;
    logic [TW-1:0]  tmo_q;
    logic [31:0]    score_q;
    logic           busy_q, done_q, error_q, cand_req_q, req_score_q;
    logic           best_valid_q;
    logic [1:0]     best_rot_q;
    logic [3:0]     best_col_q;
    logic [31:0]    best_score_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rot_q        <= '0;
            col_q        <= '0;
            tmo_q        <= '0;
            score_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cand_req_q   <= 1'b0;
            req_score_q  <= 1'b0;
            best_valid_q <= 1'b0;
            best_rot_q   <= '0;
            best_col_q   <= '0;
            best_score_q <= SCORE_MAX;
        end else begin
            // Pulse outputs default low so they can never be held two cycles.
            done_q      <= 1'b0;
            req_score_q <= 1'b0;
            if (abort && state_q != S_IDLE) begin
                state_q    <= S_IDLE;
                busy_q     <= 1'b0;
                cand_req_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state_q      <= S_GEN;
                            rot_q        <= '0;
                            col_q        <= '0;
                            tmo_q        <= '0;
                            error_q      <= 1'b0;
                            best_valid_q <= 1'b0;
                            best_rot_q   <= '0;
                            best_col_q   <= '0;
                            best_score_q <= SCORE_MAX;
                            busy_q       <= 1'b1;
                            cand_req_q   <= 1'b1;
                        end
                    end
                    S_GEN: begin
                        if (cand_ack) begin
                            cand_req_q <= 1'b0;
                            if (cand_legal) begin
                                state_q     <= S_SCORE;
                                req_score_q <= 1'b1;
                            end else begin
                                state_q <= S_NEXT;
                            end
                        end else if (tmo_q == TMO_LAST) begin
                            cand_req_q <= 1'b0;
                            error_q    <= 1'b1;
                            done_q     <= 1'b1;
                            state_q    <= S_FINISH;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    S_SCORE: begin
                        state_q <= S_WAIT;
                        tmo_q   <= '0;
                    end
                    S_WAIT: begin
                        // A result on the last allowed cycle still counts.
                        if (recv_score) begin
                            score_q <= score;
                            state_q <= S_UPDATE;
                        end else if (tmo_q == TMO_LAST) begin
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    S_UPDATE: begin
                        // Strict less-than: on a tie the earlier candidate stays.
                        if ($signed(score_q) < $signed(best_score_q)) begin
                            best_score_q <= score_q;
                            best_rot_q   <= rot_q;
                            best_col_q   <= col_q;
                            best_valid_q <= 1'b1;
                        end
                        state_q <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (col_q == COL_LAST && rot_q == ROT_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            if (col_q == COL_LAST) begin
                                col_q <= '0;
                                rot_q <= rot_q + 1'b1;
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                            tmo_q      <= '0;
                            cand_req_q <= 1'b1;
                            state_q    <= S_GEN;
                        end
                    end
                    S_FINISH: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign best_valid = best_valid_q;
    assign best_rot   = best_rot_q;
    assign best_col   = best_col_q;
    assign best_score = best_score_q;
    assign cand_req   = cand_req_q;
    assign cand_rot   = rot_q;
    assign cand_col   = col_q;
    assign req_score  = req_score_q;

endmodule

// File: tb/tb_placement_scheduler.sv
// Purpose: directed self-checking bench for placement_scheduler with a candidate-list model.
// Latency: generator acks in the first request cycle; analyzer answers 2 cycles after req_score.
// Backpressure: generator can be held off (gen_hold) and analyzer silenced (answer_en).
module tb_placement_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        cand_ack = 1'b0;
    logic        cand_legal = 1'b0;
    logic        recv_score = 1'b0;
    logic [31:0] score = '0;
    logic        busy, done, error, best_valid, cand_req, req_score;
    logic [1:0]  best_rot, cand_rot;
    logic [3:0]  best_col, cand_col;
    logic [31:0] best_score;

    placement_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .error(error),
        .best_valid(best_valid), .best_rot(best_rot), .best_col(best_col),
        .best_score(best_score),
        .cand_req(cand_req), .cand_rot(cand_rot), .cand_col(cand_col),
        .cand_ack(cand_ack), .cand_legal(cand_legal),
        .req_score(req_score), .recv_score(recv_score), .score(score)
    );

    always #5 clk = ~clk;

    bit          legal_t [40];
    logic [31:0] sc_t    [40];
    bit          answer_en = 1'b1;
    bit          gen_hold  = 1'b0;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int cur_idx();
        return int'(cand_rot) * 10 + int'(cand_col);
    endfunction

    // Placement generator: acknowledges in the first cycle the request is seen.
    always @(posedge clk) begin
        #1;
        cand_ack   = cand_req && !gen_hold;
        cand_legal = cand_req && !gen_hold && (cur_idx() < 40) && legal_t[cur_idx()];
    end

    // Analyzer: result strobe two cycles after the req_score pulse.
    bit          req_seen = 1'b0;
    logic [31:0] req_sc   = '0;
    bit          pend     = 1'b0;
    logic [31:0] pend_sc  = '0;
    always @(negedge clk) begin
        req_seen = req_score;
        req_sc   = (cur_idx() < 40) ? sc_t[cur_idx()] : 32'h0;
    end
    always @(posedge clk) begin
        #1;
        recv_score = pend;
        score      = pend_sc;
        pend       = req_seen && answer_en;
        pend_sc    = req_sc;
    end

    // Model: ordered list of expected candidate requests and score pulses.
    int          order_q[$];
    int          pulse_q[$];
    bit          mon_on  = 1'b0;
    bit          prev_rs = 1'b0;
    bit          prev_rq = 1'b0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mon_on) begin
            if (req_score) begin
                chk("req_single", 32'(prev_rs), 32'd0);
                if (pulse_q.size() > 0) begin
                    chk("req_cand", 32'(cur_idx()), 32'(pulse_q[0]));
                    void'(pulse_q.pop_front());
                end else begin
                    total++; bad++;
                    $display("FAIL req_unexpected actual=cand%0d required=no_pulse", cur_idx());
                end
            end
            if (cand_req && !prev_rq) begin
                if (order_q.size() > 0) begin
                    chk("cand_order", 32'(cur_idx()), 32'(order_q[0]));
                    void'(order_q.pop_front());
                end else begin
                    total++; bad++;
                    $display("FAIL cand_unexpected actual=cand%0d required=no_request", cur_idx());
                end
            end
            prev_rs = req_score;
            prev_rq = cand_req;
        end else begin
            prev_rs = 1'b0;
            prev_rq = 1'b0;
        end
    end

    task automatic run_case(input string nm, input bit to_mode);
        logic [31:0] e_score;
        int          e_rot, e_col, e_cyc, n;
        bit          e_valid, e_err, seen;
        e_valid = 0; e_err = 0; e_score = 32'h7FFF_FFFF; e_rot = 0; e_col = 0; e_cyc = 2;
        order_q.delete(); pulse_q.delete();
        for (int i = 0; i < 40; i++) begin
            order_q.push_back(i);
            if (legal_t[i]) begin
                pulse_q.push_back(i);
                if (to_mode) begin
                    e_cyc += 17;  // GEN + SCORE + TIMEOUT cycles in WAIT
                    e_err = 1;
                    break;
                end
                e_cyc += 6;
                if ($signed(sc_t[i]) < $signed(e_score)) begin
                    e_score = sc_t[i]; e_rot = i / 10; e_col = i % 10; e_valid = 1;
                end
            end else begin
                e_cyc += 2;
            end
        end
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1; mon_on = 1'b1; n = 1; seen = 0;
        while (!seen && n < 600) begin
            @(negedge clk);
            start = 1'b0;
            n++;
            chk({nm, "_busy"}, 32'(busy), 32'd1);
            if (done) seen = 1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s_done_timeout actual=no_done required=done_within_600", nm);
        end
        chk({nm, "_cycles"}, 32'(n), 32'(e_cyc));
        chk({nm, "_valid"}, 32'(best_valid), 32'(e_valid));
        chk({nm, "_rot"}, 32'(best_rot), 32'(e_rot));
        chk({nm, "_col"}, 32'(best_col), 32'(e_col));
        chk({nm, "_score"}, best_score, e_score);
        chk({nm, "_error"}, 32'(error), 32'(e_err));
        @(negedge clk);
        mon_on = 1'b0;
        chk({nm, "_done_once"}, 32'(done_cnt), 32'd1);
        chk({nm, "_busy_after"}, 32'(busy), 32'd0);
        chk({nm, "_pulses_left"}, 32'(pulse_q.size()), 32'd0);
        chk({nm, "_cands_left"}, 32'(order_q.size()), 32'd0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_error"}, 32'(error), 32'd0);
        chk({nm, "_cand_req"}, 32'(cand_req), 32'd0);
        chk({nm, "_req_score"}, 32'(req_score), 32'd0);
        chk({nm, "_valid"}, 32'(best_valid), 32'd0);
        chk({nm, "_rot"}, 32'(best_rot), 32'd0);
        chk({nm, "_col"}, 32'(best_col), 32'd0);
        chk({nm, "_score"}, best_score, 32'h7FFF_FFFF);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 40; i++) begin legal_t[i] = 1; sc_t[i] = 32'(1000 - i); end
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;

        // Reset during WAIT: outputs return at once and no done follows.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!req_score && n < 50) begin @(negedge clk); n++; end
        chk("midwait_reached", 32'(req_score), 32'd1);
        @(negedge clk);
        rst_n = 1'b0; done_cnt = 0;
        #1;
        chk_reset_vals("midwait_rst");
        @(negedge clk); rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midwait_no_done", 32'(done_cnt), 32'd0);
        chk("midwait_idle_busy", 32'(busy), 32'd0);
        chk("midwait_late_recv", 32'(best_valid), 32'd0);

        // Descending scores: last candidate wins.
        run_case("desc", 0);
        chk("desc_lit_rot", 32'(best_rot), 32'd3);
        chk("desc_lit_col", 32'(best_col), 32'd9);
        chk("desc_lit_score", best_score, 32'd961);

        // All equal: first candidate kept.
        for (int i = 0; i < 40; i++) sc_t[i] = 32'd500;
        run_case("tie", 0);
        chk("tie_lit_rot", 32'(best_rot), 32'd0);
        chk("tie_lit_col", 32'(best_col), 32'd0);

        // Only (2,4) legal with a negative score.
        for (int i = 0; i < 40; i++) begin legal_t[i] = (i == 24); sc_t[i] = 32'd7; end
        sc_t[24] = 32'hFFFF_F000;
        run_case("single", 0);
        chk("single_lit_score", best_score, 32'hFFFF_F000);
        chk("single_lit_rot", 32'(best_rot), 32'd2);
        chk("single_lit_col", 32'(best_col), 32'd4);

        // Nothing legal.
        for (int i = 0; i < 40; i++) legal_t[i] = 0;
        run_case("none", 0);
        chk("none_lit_score", best_score, 32'h7FFF_FFFF);

        // Analyzer silent: timeout on the first legal candidate.
        for (int i = 0; i < 40; i++) begin legal_t[i] = 1; sc_t[i] = 32'd100; end
        answer_en = 1'b0;
        run_case("tmo", 1);
        chk("tmo_lit_error", 32'(error), 32'd1);
        answer_en = 1'b1;

        // Next start clears error; abort in GEN returns to IDLE without done.
        gen_hold = 1'b1; done_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_err_cleared", 32'(error), 32'd0);
        chk("abort_in_gen", 32'(cand_req), 32'd1);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_cand_req", 32'(cand_req), 32'd0);
        chk("abort_busy_low", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        gen_hold = 1'b0;

        // Abort and start together in IDLE: abort wins.
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);
        chk("abort_start_req", 32'(cand_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
